// File: rtl/cmpgt_max_seq.sv
// cmpgt_max_seq: sequences an external W-bit greater-than comparator to find a frame's maximum
// and the index of its first occurrence.
module cmpgt_max_seq #(
    parameter int W  = 4,
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic [W-1:0]  cmp_a,
    output logic [W-1:0]  cmp_b,
    input  logic          cmp_gt,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  max_out,
    output logic [IW-1:0] max_idx
);
    typedef enum logic [1:0] {IDLE, FIRST, SCAN, DONE} state_t;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    state_t        r_state;
    logic [W-1:0]  r_cur_max;
    logic [IW-1:0] r_cur_idx;
    logic [IW-1:0] r_cnt;
    logic          w_accept;
    logic [W-1:0]  w_nxt_max;
    logic [IW-1:0] w_nxt_idx;
    assign in_ready  = (r_state == FIRST || r_state == SCAN) && !abort;
    assign w_accept  = in_valid && in_ready;
    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
    assign cmp_a     = in_data;
    assign cmp_b     = r_cur_max;
    // Ties keep the incumbent so the earliest index wins.
    assign w_nxt_max = cmp_gt ? in_data : r_cur_max;
    assign w_nxt_idx = cmp_gt ? r_cnt : r_cur_idx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cur_max <= '0;
            r_cur_idx <= '0;
            r_cnt     <= '0;
            max_out   <= '0;
            max_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (start && !abort) r_state <= FIRST;
                end
                FIRST: begin
                    if (abort) r_state <= IDLE;
                    else if (w_accept) begin
                        r_cur_max <= in_data;
                        r_cur_idx <= '0;
                        r_cnt     <= IW'(1);
                        r_state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (abort) r_state <= IDLE;
                    else if (w_accept) begin
                        r_cur_max <= w_nxt_max;
                        r_cur_idx <= w_nxt_idx;
                        r_cnt     <= r_cnt + IW'(1);
                        if (r_cnt == LAST) begin
                            max_out <= w_nxt_max;
                            max_idx <= w_nxt_idx;
                            r_state <= DONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmpgt_max_seq.sv
// tb_cmpgt_max_seq: random and directed frames against a first-occurrence maximum model.
module tb_cmpgt_max_seq;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       start = 0;
    logic       abort = 0;
    logic       in_valid = 0;
    logic [3:0] in_data = 0;
    logic       in_ready;
    logic [3:0] cmp_a;
    logic [3:0] cmp_b;
    logic       cmp_gt;
    logic       busy;
    logic       done;
    logic [3:0] max_out;
    logic [2:0] max_idx;
    int n_vec = 0;
    int n_err = 0;
    logic [3:0] f [8];

    cmpgt_max_seq #(.W(4), .N(8), .IW(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt),
        .busy(busy), .done(done), .max_out(max_out), .max_idx(max_idx)
    );

    assign cmp_gt = cmp_a > cmp_b;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // gap_mode: 0 none, 1 one idle cycle before each beat, 2 random idles
    task automatic run_frame(input logic [3:0] v [8], input int gap_mode);
        int em = -1;
        int ei = 0;
        int rm = 0;
        int cyc = 0;
        for (int i = 0; i < 8; i++) if (int'(v[i]) > em) begin em = v[i]; ei = i; end
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 8; i++) begin
            bit acc = 0;
            int tries = 0;
            while (!acc && tries < 64) begin
                in_valid = gap_mode == 0 ? 1'b1 : gap_mode == 1 ? (tries > 0) : ($urandom_range(99) >= 30);
                in_data = in_valid ? v[i] : 4'($urandom);
                #1;
                chk("in_ready", in_ready, 1);
                if (in_valid && i > 0) chk("cmp_b_runmax", cmp_b, rm);
                acc = in_valid && in_ready;
                @(negedge clk);
                cyc++;
                tries++;
            end
            if (!acc) chk("accept_timeout", 0, 1);
            rm = (i == 0 || int'(v[i]) > rm) ? v[i] : rm;
        end
        in_valid = 0;
        if (gap_mode == 0) chk("accept_cycles", cyc, 8);
        chk("done", done, 1);
        chk("busy_done", busy, 1);
        chk("in_ready_done", in_ready, 0);
        chk("max_out", max_out, em);
        chk("max_idx", max_idx, ei);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("max_out_hold", max_out, em);
    endtask

    initial begin
        #2;
        chk("rst_max_out", max_out, 0);
        chk("rst_max_idx", max_idx, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        in_data = 4'h6;
        #1;
        chk("cmp_a_idle", cmp_a, 6);
        chk("cmp_b_idle", cmp_b, 0);
        f = '{4'h3, 4'h9, 4'h2, 4'hF, 4'hF, 4'h1, 4'h0, 4'h7}; run_frame(f, 0);
        f = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5}; run_frame(f, 0);
        f = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7}; run_frame(f, 0);
        f = '{4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0}; run_frame(f, 0);
        f = '{4'hA, 4'h1, 4'hB, 4'h2, 4'hC, 4'h3, 4'hD, 4'h4}; run_frame(f, 1);
        f = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h9, 4'h0, 4'h4, 4'h8}; run_frame(f, 0);
        // abort after 4 accepts; a start pulsed mid-frame must be ignored
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1;
            in_data = 4'hE;
            start = i == 2;
            @(negedge clk);
        end
        start = 0;
        abort = 1;
        #1;
        chk("abort_in_ready", in_ready, 0);
        @(negedge clk);
        abort = 0;
        in_valid = 0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_in_ready_after", in_ready, 0);
        chk("abort_max_out", max_out, 9);
        chk("abort_max_idx", max_idx, 1);
        repeat (3) @(negedge clk);
        chk("abort_still_idle", busy, 0);
        start = 1;
        abort = 1;
        @(negedge clk);
        start = 0;
        abort = 0;
        chk("start_abort_idle", busy, 0);
        // asynchronous reset mid-SCAN
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1;
            in_data = 4'(i + 3);
            @(negedge clk);
        end
        #2 rst_n = 0;
        #1;
        chk("arst_max_out", max_out, 0);
        chk("arst_max_idx", max_idx, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_done", done, 0);
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        f = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8}; run_frame(f, 0);
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < 8; i++) f[i] = 4'($urandom);
            run_frame(f, k % 3);
            if ($urandom_range(3) == 0) @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
